// File: rtl/cube_pkg.sv
// Shared types and timing helpers for the LED cube layer scanner.
package cube_pkg;

    typedef enum logic [1:0] {StShift, StBlank, StLatch, StShow} state_e;

    // Counter width that never collapses to zero bits.
    function automatic int unsigned cnt_w(input int unsigned v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

    function automatic int unsigned idx(input int unsigned x, input int unsigned y,
                                        input int unsigned z, input int unsigned n);
        return z * n * n + y * n + x;
    endfunction

    function automatic int unsigned shift_cycles(input int unsigned n,
                                                 input int unsigned sclk_div);
        return n * n * 2 * sclk_div;
    endfunction

    function automatic int unsigned layer_period(input int unsigned n, input int unsigned sclk_div,
                                                 input int unsigned blank, input int unsigned dwell);
        return shift_cycles(n, sclk_div) + blank + 1 + dwell;
    endfunction

    localparam int unsigned DefaultLayerPeriod = layer_period(8, 2, 16, 1024);

endpackage

// File: rtl/cube_shift_out.sv
// Parallel-load serialiser: MSB first, each bit held SCLK_DIV cycles low then SCLK_DIV high.
module cube_shift_out
    import cube_pkg::*;
#(
    parameter int unsigned WIDTH    = 64,
    parameter int unsigned SCLK_DIV = 2
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             done_o,
    output logic             ser_data_o,
    output logic             ser_clk_o
);

    localparam int unsigned DW = cnt_w(SCLK_DIV);
    localparam int unsigned BW = cnt_w(WIDTH);
    localparam logic [DW-1:0] DivLast = DW'(SCLK_DIV - 1);
    localparam logic [BW-1:0] BitLast = BW'(WIDTH - 1);

    logic             active_q, active_d;
    logic             hi_q, hi_d;
    logic [DW-1:0]    div_q, div_d;
    logic [BW-1:0]    left_q, left_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;

    logic             cur_active, cur_hi;
    logic [DW-1:0]    cur_div;
    logic [BW-1:0]    cur_left;
    logic [WIDTH-1:0] cur_sreg;

    // The start cycle already presents the first bit, so it is folded in combinationally.
    always_comb begin
        cur_active = start_i | active_q;
        cur_hi     = start_i ? 1'b0 : hi_q;
        cur_div    = start_i ? '0 : div_q;
        cur_left   = start_i ? BitLast : left_q;
        cur_sreg   = start_i ? data_i : sreg_q;

        active_d = cur_active;
        hi_d     = cur_hi;
        div_d    = cur_div;
        left_d   = cur_left;
        sreg_d   = cur_sreg;
        done_o   = 1'b0;

        if (cur_active) begin
            if (cur_div == DivLast) begin
                div_d = '0;
                hi_d  = ~cur_hi;
                if (cur_hi) begin
                    if (cur_left == '0) begin
                        done_o   = 1'b1;
                        active_d = 1'b0;
                    end else begin
                        left_d = cur_left - 1'b1;
                        sreg_d = cur_sreg << 1;
                    end
                end
            end else begin
                div_d = cur_div + 1'b1;
            end
        end

        ser_data_o = cur_active & cur_sreg[WIDTH-1];
        ser_clk_o  = cur_active & cur_hi;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            active_q <= 1'b0;
            hi_q     <= 1'b0;
            div_q    <= '0;
            left_q   <= BitLast;
            sreg_q   <= '0;
        end else begin
            active_q <= active_d;
            hi_q     <= hi_d;
            div_q    <= div_d;
            left_q   <= left_d;
            sreg_q   <= sreg_d;
        end
    end

endmodule

// File: rtl/cube_layer_scanner.sv
// Multiplexes an N x N x N LED cube layer by layer from a double-buffered frame.
module cube_layer_scanner
    import cube_pkg::*;
#(
    parameter int unsigned N        = 8,
    parameter int unsigned DWELL    = 1024,
    parameter int unsigned BLANK    = 16,
    parameter int unsigned SCLK_DIV = 2
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic [N*N*N-1:0]     Cells,
    input  logic                 Frame_valid,
    output logic                 Frame_ack,
    output logic                 Frame_start,
    output logic                 Ser_data,
    output logic                 Ser_clk,
    output logic                 Ser_latch,
    output logic [N-1:0]         Layer_en,
    output logic [$clog2(N)-1:0] Layer_idx
);

    localparam int unsigned NN = N * N;
    localparam int unsigned IW = $clog2(N);
    localparam int unsigned CW = cnt_w((BLANK > DWELL) ? BLANK : DWELL);
    localparam logic [IW-1:0] LastLayer = IW'(N - 1);
    localparam logic [CW-1:0] BlankLast = CW'(BLANK - 1);
    localparam logic [CW-1:0] DwellLast = CW'(DWELL - 1);

    state_e           state_q, state_d;
    logic             first_q, first_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [N-1:0]     en_q, en_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [N*N*N-1:0] shadow_q, shadow_d;
    logic [NN-1:0]    layer_bits;
    logic             shift_start, shift_done;

    // Cells is only looked at on the first SHIFT cycle of layer 0, so a frame never tears.
    always_comb begin
        Frame_start = first_q && (idx_q == '0) && !Reset;
        Frame_ack   = Frame_start && Frame_valid;
        shift_start = first_q && !Reset;
        shadow_d    = Frame_ack ? Cells : shadow_q;
        layer_bits  = shadow_d[32'(idx_q) * NN +: NN];
        Ser_latch   = (state_q == StLatch) && !Reset;
        Layer_en    = en_q;
        Layer_idx   = idx_q;
    end

    always_comb begin
        state_d = state_q;
        first_d = 1'b0;
        idx_d   = idx_q;
        en_d    = en_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StShift: begin
                if (shift_done) begin
                    state_d = StBlank;
                    en_d    = '0;
                    cnt_d   = '0;
                end
            end
            StBlank: begin
                if (cnt_q == BlankLast) begin
                    state_d = StLatch;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StLatch: begin
                state_d     = StShow;
                en_d        = '0;
                en_d[idx_q] = 1'b1;
                cnt_d       = '0;
            end
            StShow: begin
                if (cnt_q == DwellLast) begin
                    state_d = StShift;
                    first_d = 1'b1;
                    cnt_d   = '0;
                    idx_d   = (idx_q == LastLayer) ? '0 : idx_q + 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StShift;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q  <= StShift;
            first_q  <= 1'b1;
            idx_q    <= '0;
            en_q     <= '0;
            cnt_q    <= '0;
            shadow_q <= '0;
        end else begin
            state_q  <= state_d;
            first_q  <= first_d;
            idx_q    <= idx_d;
            en_q     <= en_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
        end
    end

    cube_shift_out #(
        .WIDTH    (NN),
        .SCLK_DIV (SCLK_DIV)
    ) u_shift_out (
        .clk_i      (Clk),
        .reset_i    (Reset),
        .start_i    (shift_start),
        .data_i     (layer_bits),
        .done_o     (shift_done),
        .ser_data_o (Ser_data),
        .ser_clk_o  (Ser_clk)
    );

endmodule
